// File: rtl/led_pkg.sv
// Shared mode encoding for the multi-channel LED driver.
// Imported by the channel and top modules.
package led_pkg;

  localparam int LED_MODE_W = 2;

  typedef enum logic [LED_MODE_W-1:0] {
    LED_MODE_OFF     = 2'd0,
    LED_MODE_ON      = 2'd1,
    LED_MODE_BLINK   = 2'd2,
    LED_MODE_ONESHOT = 2'd3
  } led_mode_t;

  // LED level that a freshly loaded mode starts from.
  function automatic logic led_init(input led_mode_t m);
    return (m == LED_MODE_ON) || (m == LED_MODE_ONESHOT);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode, half-period, counter and output flops.
// Writes win over sync; reset wins over everything.
module led_channel
  import led_pkg::*;
#(
  parameter int g_CNT_WIDTH      = 24,
  parameter int g_DEFAULT_PERIOD = 12500000,
  parameter int g_RESET_MODE     = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Wr,
  input  led_mode_t              i_Mode,
  input  logic [g_CNT_WIDTH-1:0] i_Period,
  input  logic                   i_Sync,
  output logic                   o_LED,
  output logic                   o_Done
);

  localparam led_mode_t RST_MODE =
    led_mode_t'(g_RESET_MODE[LED_MODE_W-1:0]);
  localparam logic [g_CNT_WIDTH-1:0] RST_PER =
    g_CNT_WIDTH'(g_DEFAULT_PERIOD);
  localparam logic [g_CNT_WIDTH-1:0] ONE = g_CNT_WIDTH'(1);

  led_mode_t              mode_q, mode_d;
  logic [g_CNT_WIDTH-1:0] per_q, per_d;
  logic [g_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   led_q, led_d;
  logic                   done_d;
  logic                   term;

  assign term = (cnt_q == per_q);

  // State register; reset restores the power-on channel config.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      mode_q <= RST_MODE;
      per_q  <= RST_PER;
      cnt_q  <= '0;
      led_q  <= led_init(RST_MODE);
      o_Done <= 1'b0;
    end else begin
      mode_q <= mode_d;
      per_q  <= per_d;
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      o_Done <= done_d;
    end
  end

  // Next-state: config load, else per-mode counting and toggling.
  always_comb begin
    mode_d = mode_q;
    per_d  = per_q;
    cnt_d  = cnt_q;
    led_d  = led_q;
    done_d = 1'b0;
    if (i_Wr) begin
      mode_d = i_Mode;
      per_d  = i_Period;
      cnt_d  = '0;
      led_d  = led_init(i_Mode);
    end else begin
      unique case (mode_q)
        LED_MODE_OFF: begin
          cnt_d = '0;
          led_d = 1'b0;
        end
        LED_MODE_ON: begin
          cnt_d = '0;
          led_d = 1'b1;
        end
        LED_MODE_BLINK: begin
          if (i_Sync) begin
            cnt_d = '0;
            led_d = 1'b0;
          end else if (term) begin
            cnt_d = '0;
            led_d = ~led_q;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        LED_MODE_ONESHOT: begin
          if (term) begin
            mode_d = LED_MODE_OFF;
            cnt_d  = '0;
            led_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        default: begin
          mode_d = LED_MODE_OFF;
        end
      endcase
    end
  end

  assign o_LED = led_q;

endmodule

// File: rtl/led_blink_multi.sv
// Multi-channel LED driver with per-channel mode and period.
// Decodes the config port and fans out to g_NUM_CH channels.
module led_blink_multi
  import led_pkg::*;
#(
  parameter int g_NUM_CH         = 4,
  parameter int g_CNT_WIDTH      = 24,
  parameter int g_DEFAULT_PERIOD = 12500000,
  parameter int g_RESET_MODE     = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Cfg_Wr,
  input  logic [3:0]             i_Cfg_Ch,
  input  logic [1:0]             i_Cfg_Mode,
  input  logic [g_CNT_WIDTH-1:0] i_Cfg_Period,
  input  logic                   i_Sync,
  output logic [g_NUM_CH-1:0]    o_LED,
  output logic [g_NUM_CH-1:0]    o_Done
);

  led_mode_t cfg_mode;
  assign cfg_mode = led_mode_t'(i_Cfg_Mode);

  for (genvar g = 0; g < g_NUM_CH; g++) begin : g_ch
    // Out-of-range indices match no channel, so they are dropped.
    logic wr_en;
    assign wr_en = i_Cfg_Wr && (i_Cfg_Ch == 4'(g));

    led_channel #(
      .g_CNT_WIDTH      (g_CNT_WIDTH),
      .g_DEFAULT_PERIOD (g_DEFAULT_PERIOD),
      .g_RESET_MODE     (g_RESET_MODE)
    ) u_ch (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .i_Wr     (wr_en),
      .i_Mode   (cfg_mode),
      .i_Period (i_Cfg_Period),
      .i_Sync   (i_Sync),
      .o_LED    (o_LED[g]),
      .o_Done   (o_Done[g])
    );
  end

endmodule

// File: tb/tb_led_blink_multi.sv
// Bench for led_blink_multi: directed plan then random traffic.
// Reference model derives outputs from time since each channel's anchor.
module tb_led_blink_multi;

  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int DEF_PER = 3;
  localparam int RST_MODE = 2;

  logic          i_Clk = 0;
  logic          i_Rst = 0;
  logic          i_Cfg_Wr = 0;
  logic [3:0]    i_Cfg_Ch = 0;
  logic [1:0]    i_Cfg_Mode = 0;
  logic [CW-1:0] i_Cfg_Period = 0;
  logic          i_Sync = 0;
  logic [NCH-1:0] o_LED;
  logic [NCH-1:0] o_Done;

  led_blink_multi #(
    .g_NUM_CH         (NCH),
    .g_CNT_WIDTH      (CW),
    .g_DEFAULT_PERIOD (DEF_PER),
    .g_RESET_MODE     (RST_MODE)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Cfg_Wr     (i_Cfg_Wr),
    .i_Cfg_Ch     (i_Cfg_Ch),
    .i_Cfg_Mode   (i_Cfg_Mode),
    .i_Cfg_Period (i_Cfg_Period),
    .i_Sync       (i_Sync),
    .o_LED        (o_LED),
    .o_Done       (o_Done)
  );

  always #5 i_Clk = ~i_Clk;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int m_mode[NCH];
  int m_per[NCH];
  int m_anc[NCH];
  logic [NCH-1:0] exp_led, exp_done;

  // Model: mode 0 OFF, 1 ON, 2 BLINK, 3 ONESHOT; anchor = last load edge.
  task automatic model_edge();
    cyc++;
    for (int n = 0; n < NCH; n++) begin
      if (i_Rst) begin
        m_mode[n] = RST_MODE;
        m_per[n]  = DEF_PER;
        m_anc[n]  = cyc;
      end else if (i_Cfg_Wr && int'(i_Cfg_Ch) == n) begin
        m_mode[n] = int'(i_Cfg_Mode);
        m_per[n]  = int'(i_Cfg_Period);
        m_anc[n]  = cyc;
      end else if (i_Sync && m_mode[n] == 2) begin
        m_anc[n] = cyc;
      end
    end
    for (int n = 0; n < NCH; n++) begin
      int e;
      int h;
      e = cyc - m_anc[n];
      h = m_per[n] + 1;
      exp_done[n] = 1'b0;
      case (m_mode[n])
        1: exp_led[n] = 1'b1;
        2: exp_led[n] = ((e / h) % 2) == 1;
        3: begin
          exp_led[n]  = (e < h);
          exp_done[n] = (e == h);
        end
        default: exp_led[n] = 1'b0;
      endcase
    end
  endtask

  task automatic tick(input string tag);
    @(posedge i_Clk);
    model_edge();
    #1;
    total++;
    assert (o_LED === exp_led) passed++;
    else $error("FAIL %s led cyc=%0d got=%b exp=%b",
                tag, cyc, o_LED, exp_led);
    total++;
    assert (o_Done === exp_done) passed++;
    else $error("FAIL %s done cyc=%0d got=%b exp=%b",
                tag, cyc, o_Done, exp_done);
  endtask

  task automatic run(input int k, input string tag);
    for (int i = 0; i < k; i++) tick(tag);
  endtask

  task automatic wr(input int ch, input int md, input int per,
                    input logic sy, input string tag);
    i_Cfg_Wr     = 1'b1;
    i_Cfg_Ch     = 4'(ch);
    i_Cfg_Mode   = 2'(md);
    i_Cfg_Period = CW'(per);
    i_Sync       = sy;
    tick(tag);
    i_Cfg_Wr = 1'b0;
    i_Sync   = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < NCH; n++) begin
      m_mode[n] = RST_MODE;
      m_per[n]  = DEF_PER;
      m_anc[n]  = 0;
    end
    i_Rst = 1'b1;
    run(2, "reset");
    i_Rst = 1'b0;
    run(17, "blink_all");

    wr(1, 2, 0, 1'b0, "ch1_fast");
    run(6, "ch1_fast");

    wr(2, 3, 5, 1'b0, "ch2_oneshot");
    run(10, "ch2_oneshot");

    wr(0, 3, 9, 1'b0, "ch0_os");
    run(3, "ch0_os");
    wr(0, 1, 0, 1'b0, "ch0_replace");
    run(12, "ch0_on");

    wr(0, 3, 9, 1'b0, "ch0_os2");
    run(4, "ch0_os2");
    i_Rst = 1'b1;
    tick("rst_mid_os");
    i_Rst = 1'b0;
    run(12, "after_rst");

    wr(0, 2, 7, 1'b0, "ch0_b7");
    run(2, "phase");
    wr(1, 2, 3, 1'b0, "ch1_b3");
    run(5, "phase");
    i_Sync = 1'b1;
    tick("sync");
    i_Sync = 1'b0;
    run(10, "post_sync");
    wr(1, 2, 1, 1'b1, "sync_wr");
    run(10, "post_sync_wr");

    wr(4, 1, 2, 1'b0, "bad_ch");
    run(4, "bad_ch");
    wr(3, 0, 0, 1'b0, "ch3_off");
    run(2, "ch3_off");
    wr(3, 1, 0, 1'b0, "ch3_on");
    run(2, "ch3_on");

    for (int i = 0; i < 600; i++) begin
      i_Rst  = ($urandom_range(0, 63) == 0);
      i_Sync = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        i_Cfg_Wr     = 1'b1;
        i_Cfg_Ch     = 4'($urandom_range(0, 5));
        i_Cfg_Mode   = 2'($urandom_range(0, 3));
        i_Cfg_Period = CW'($urandom_range(0, 6));
      end
      tick("random");
      i_Rst    = 1'b0;
      i_Sync   = 1'b0;
      i_Cfg_Wr = 1'b0;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
